matmul_sched: RTL and testbench

MATMUL_SCHED -- requirements
Module: matmul_sched

---
 rtl/matmul_pkg.sv | 36 +++
 rtl/matmul_mac.sv | 28 ++
 rtl/matmul_sched.sv | 120 ++++++++++++
 tb/tb_matmul_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply scheduler.
// The optional range check is enabled by defining MATMUL_RANGE_CHECK_EN.
package matmul_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int ELEM_W      = 2;
  localparam int RES_W       = 5;
  localparam int NUM_STEPS   = 8;
  localparam int MAX_OPERAND = 2;

  localparam int A11_OFS = 0;
  localparam int A12_OFS = 2;
  localparam int A21_OFS = 4;
  localparam int A22_OFS = 6;

  localparam int C11_OFS = 0;
  localparam int C12_OFS = 5;
  localparam int C21_OFS = 10;
  localparam int C22_OFS = 15;

  // Element index follows the operand packing: 0=x11, 1=x12, 2=x21, 3=x22.
  function automatic logic [ELEM_W-1:0] get_elem(input logic [7:0] m, input logic [1:0] idx);
    return m[{idx, 1'b0} +: ELEM_W];
  endfunction

  function automatic logic out_of_range(input logic [7:0] m);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (int'(get_elem(m, 2'(i))) > MAX_OPERAND) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Shared 2x2-bit multiply with 5-bit accumulator; 'sum' is the value the
// accumulator takes on the next enabled edge, so it can be written out directly.
module matmul_mac
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [RES_W-1:0]  sum
);

  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] prod;

  always_comb begin
    prod = RES_W'(a) * RES_W'(b);
    sum  = (clear ? '0 : acc) + prod;
  end

  always_ff @(posedge clk) begin
    if (reset) acc <= '0;
    else if (en) acc <= sum;
  end

endmodule

// File: rtl/matmul_sched.sv
// 2x2 matrix multiply scheduled over 8 cycles on one shared MAC.
// Define MATMUL_RANGE_CHECK_EN to reject operands above MAX_OPERAND.
module matmul_sched
  import matmul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] c_out,
  output logic        out_err,
  output logic        busy,
  output logic [7:0]  job_count
);

  state_t            state, state_next;
  logic [2:0]        step;
  logic [7:0]        a_reg, b_reg;
  logic              range_err;
  logic              step_last;
  logic              mac_en, mac_clear;
  logic [ELEM_W-1:0] mac_a, mac_b;
  logic [RES_W-1:0]  mac_sum;

  assign step_last = (step == 3'(NUM_STEPS - 1));

`ifdef MATMUL_RANGE_CHECK_EN
  logic err_q;

  assign range_err = out_of_range(a_in) | out_of_range(b_in);
  assign out_err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (ena && state == IDLE && in_valid) err_q <= range_err;
  end
`else
  assign range_err = 1'b0;
  assign out_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (ena && in_valid) state_next = range_err ? DONE : CALC;
      CALC: if (ena && step_last) state_next = DONE;
      DONE: if (ena && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // step[2:1] selects the result element (row, col); step[0] selects the inner-product term.
  assign mac_a     = get_elem(a_reg, {step[2], step[0]});
  assign mac_b     = get_elem(b_reg, {step[0], step[1]});
  assign mac_clear = ~step[0];
  assign mac_en    = ena && (state == CALC);

  matmul_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (mac_en),
    .clear (mac_clear),
    .a     (mac_a),
    .b     (mac_b),
    .sum   (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      step      <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_out     <= '0;
      job_count <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a_in;
            b_reg <= b_in;
            step  <= '0;
            if (range_err) c_out <= '0;
          end
        end
        CALC: begin
          step <= step + 3'd1;
          if (step[0]) begin
            case (step[2:1])
              2'd0: c_out[C11_OFS +: RES_W] <= mac_sum;
              2'd1: c_out[C12_OFS +: RES_W] <= mac_sum;
              2'd2: c_out[C21_OFS +: RES_W] <= mac_sum;
              default: c_out[C22_OFS +: RES_W] <= mac_sum;
            endcase
          end
        end
        DONE: begin
          if (out_ready) job_count <= job_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sched.sv
// Self-checking bench for matmul_sched against a plain-arithmetic matrix model.
// Range-path expectations follow MATMUL_RANGE_CHECK_EN when it is defined.
module tb_matmul_sched;

  logic        clk = 1'b0;
  logic        reset, ena, in_valid, out_ready;
  logic [7:0]  a_in, b_in;
  logic        in_ready, out_valid, out_err, busy;
  logic [19:0] c_out;
  logic [7:0]  job_count;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_jobs = 8'd0;

  always #5 clk = ~clk;

  matmul_sched dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out),
    .out_err   (out_err),
    .busy      (busy),
    .job_count (job_count)
  );

  // C = A x B with A, B unpacked from 2-bit fields: index = 2*row + col.
  function automatic logic [19:0] model_c(input logic [7:0] a, input logic [7:0] b);
    int am[2][2];
    int bm[2][2];
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        am[i][j] = int'((a >> (2 * (2 * i + j))) & 8'd3);
        bm[i][j] = int'((b >> (2 * (2 * i + j))) & 8'd3);
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        r = r | (20'(am[i][0] * bm[0][j] + am[i][1] * bm[1][j]) << (5 * (2 * i + j)));
    return r;
  endfunction

  function automatic logic model_err(input logic [7:0] a, input logic [7:0] b);
    logic e;
    e = 1'b0;
`ifdef MATMUL_RANGE_CHECK_EN
    for (int k = 0; k < 4; k++)
      if (((a >> (2 * k)) & 8'd3) > 8'd2 || ((b >> (2 * k)) & 8'd3) > 8'd2) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [7:0] rand_ok();
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v = v | (8'($urandom_range(2)) << (2 * k));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen; capped so a stuck DUT cannot hang.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_jobs  = exp_jobs + 8'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ena   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    ena   = 1'b1;
    checks++;
    if ({in_ready, out_valid, busy, out_err} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 1000", {in_ready, out_valid, busy, out_err});
    end
    checks++;
    if (c_out !== 20'd0 || job_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got c=%h jobs=%0d expected c=0 jobs=0", c_out, job_count);
    end
  endtask

  task automatic test_all_twos();
    int lat;
    accept(8'hAA, 8'hAA);
    wait_valid(lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("[TB] FAIL twos_latency: got %0d expected 8", lat);
    end
    checks++;
    if (c_out !== {5'd8, 5'd8, 5'd8, 5'd8}) begin
      errors++;
      $display("[TB] FAIL twos_result: got %h expected %h", c_out, {5'd8, 5'd8, 5'd8, 5'd8});
    end
    handshake();
    checks++;
    if (job_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL twos_jobcount: got %0d expected 1", job_count);
    end
  endtask

  task automatic test_identity();
    int lat;
    accept(8'h41, 8'h9A);
    wait_valid(lat);
    checks++;
    if (lat !== 8 || out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ident_latency: got lat=%0d valid=%b busy=%b expected 8 1 1", lat, out_valid, busy);
    end
    checks++;
    if (c_out !== {5'd2, 5'd1, 5'd2, 5'd2} || out_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ident_result: got %h err=%b expected %h err=0", c_out, out_err, {5'd2, 5'd1, 5'd2, 5'd2});
    end
    handshake();
    checks++;
    if (job_count !== exp_jobs || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ident_done: got jobs=%0d rdy=%b expected %0d 1", job_count, in_ready, exp_jobs);
    end
  endtask

  task automatic test_range();
    int lat;
`ifdef MATMUL_RANGE_CHECK_EN
    accept(8'h03, 8'h00);
    wait_valid(lat);
    checks++;
    if (lat !== 0 || out_err !== 1'b1 || c_out !== 20'd0) begin
      errors++;
      $display("[TB] FAIL range_reject: got lat=%0d err=%b c=%h expected 0 1 0", lat, out_err, c_out);
    end
`else
    accept(8'hFF, 8'hFF);
    wait_valid(lat);
    checks++;
    if (lat !== 8 || out_err !== 1'b0 || c_out !== {5'd18, 5'd18, 5'd18, 5'd18}) begin
      errors++;
      $display("[TB] FAIL range_max: got lat=%0d err=%b c=%h expected 8 0 %h", lat, out_err, c_out, {5'd18, 5'd18, 5'd18, 5'd18});
    end
`endif
    handshake();
    checks++;
    if (job_count !== exp_jobs) begin
      errors++;
      $display("[TB] FAIL range_jobcount: got %0d expected %0d", job_count, exp_jobs);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [7:0]  a1, b1, a2, b2;
    logic [19:0] snap;
    a1 = rand_ok(); b1 = rand_ok();
    a2 = rand_ok(); b2 = rand_ok();
    accept(a1, b1);
    wait_valid(lat);
    snap = c_out;
    checks++;
    if (lat !== 8 || snap !== model_c(a1, b1)) begin
      errors++;
      $display("[TB] FAIL bp_first: got lat=%0d c=%h expected 8 %h", lat, snap, model_c(a1, b1));
    end
    in_valid = 1'b1;
    a_in = a2;
    b_in = b2;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (c_out !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_hold: cycle %0d got c=%h rdy=%b vld=%b expected %h 0 1", i, c_out, in_ready, out_valid, snap);
      end
    end
    handshake();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || job_count !== exp_jobs) begin
      errors++;
      $display("[TB] FAIL bp_release: got rdy=%b vld=%b jobs=%0d expected 1 0 %0d", in_ready, out_valid, job_count, exp_jobs);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_next_accept: got busy=%b rdy=%b expected 1 0", busy, in_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 8 || c_out !== model_c(a2, b2)) begin
      errors++;
      $display("[TB] FAIL bp_second: got lat=%0d c=%h expected 8 %h", lat, c_out, model_c(a2, b2));
    end
    handshake();
  endtask

  task automatic test_clock_enable();
    int lat;
    logic [7:0]  a, b;
    logic [19:0] snap;
    a = rand_ok(); b = rand_ok();
    accept(a, b);
    tick();
    tick();
    snap = c_out;
    ena = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (c_out !== snap || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ena_freeze: got c=%h vld=%b busy=%b expected %h 0 1", c_out, out_valid, busy, snap);
    end
    ena = 1'b1;
    wait_valid(lat);
    lat = lat + 5;
    checks++;
    if (lat !== 11 || c_out !== model_c(a, b)) begin
      errors++;
      $display("[TB] FAIL ena_latency: got lat=%0d c=%h expected 11 %h", lat, c_out, model_c(a, b));
    end
    ena = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    ena = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || job_count !== exp_jobs) begin
      errors++;
      $display("[TB] FAIL ena_handshake_gate: got vld=%b jobs=%0d expected 1 %0d", out_valid, job_count, exp_jobs);
    end
    handshake();
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] a, b;
    for (int n = 0; n < 20; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (n[0]) begin
        a = rand_ok();
        b = rand_ok();
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rand_ready: job %0d got %b expected 1", n, in_ready);
      end
      accept(a, b);
      wait_valid(lat);
      checks++;
      if (lat !== (model_err(a, b) ? 0 : 8)) begin
        errors++;
        $display("[TB] FAIL rand_latency: a=%h b=%h got %0d expected %0d", a, b, lat, model_err(a, b) ? 0 : 8);
      end
      checks++;
      if (out_err !== model_err(a, b) || c_out !== (model_err(a, b) ? 20'd0 : model_c(a, b))) begin
        errors++;
        $display("[TB] FAIL rand_result: a=%h b=%h got c=%h err=%b expected %h %b", a, b, c_out, out_err,
                 model_err(a, b) ? 20'd0 : model_c(a, b), model_err(a, b));
      end
      for (int d = $urandom_range(3); d > 0; d--) tick();
      handshake();
      checks++;
      if (job_count !== exp_jobs) begin
        errors++;
        $display("[TB] FAIL rand_jobcount: got %0d expected %0d", job_count, exp_jobs);
      end
    end
  endtask

  task automatic test_wrap();
    int lat;
    int guard;
    guard = 0;
    do begin
      accept(8'h00, 8'h00);
      wait_valid(lat);
      handshake();
      if (exp_jobs == 8'd255) begin
        checks++;
        if (job_count !== 8'd255) begin
          errors++;
          $display("[TB] FAIL wrap_255: got %0d expected 255", job_count);
        end
      end
      guard++;
    end while (exp_jobs != 8'd0 && guard < 300);
    checks++;
    if (job_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL wrap_zero: got %0d expected 0", job_count);
    end
  endtask

  task automatic test_reset_mid_job();
    int lat;
    int seen;
    accept(8'h55, 8'h55);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_jobs = 8'd0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || job_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL midreset_state: got rdy=%b vld=%b busy=%b jobs=%0d expected 1 0 0 0",
               in_ready, out_valid, busy, job_count);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_no_result: got %0d valid cycles expected 0", seen);
    end
    accept(8'h41, 8'h9A);
    wait_valid(lat);
    checks++;
    if (lat !== 8 || c_out !== model_c(8'h41, 8'h9A)) begin
      errors++;
      $display("[TB] FAIL midreset_recover: got lat=%0d c=%h expected 8 %h", lat, c_out, model_c(8'h41, 8'h9A));
    end
    handshake();
  endtask

  initial begin
    reset     = 1'b1;
    ena       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    test_reset();
    test_all_twos();
    test_identity();
    test_range();
    test_backpressure();
    test_clock_enable();
    test_random();
    test_wrap();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
